// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Asynchronous serial receiver with start-bit validation, stop-bit
//             checking and a start-edge phase-aligned oversampling divider.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 rx_busy
);

    // Clocks per oversample tick (truncating division)
    localparam int DIV_OS = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int OS_W   = (DIV_OS > 2) ? $clog2(DIV_OS) : 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(DIV_OS - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // Reject parameter sets the datapath cannot honour
    if (DIV_OS < 2) begin : g_div_check
        $error("uart_rx: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_os_check
        $error("uart_rx: OVERSAMPLE must be even and at least 4");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bits_check
        $error("uart_rx: DATA_BITS must be within 5..9");
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [OS_W-1:0]       r_os_cnt;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  w_rxd_s;
    logic                  w_os_tick;

    assign w_rxd_s   = r_sync2;
    assign w_os_tick = (r_state != S_IDLE) && (r_os_cnt == OS_LAST);
    assign rx_busy   = (r_state != S_IDLE);

    // Two-flop synchroniser on the raw line; resets to the idle (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Oversample divider; parked at zero in IDLE so the start edge sets its phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_os_cnt <= '0;
        end else if (!enable || (r_state == S_IDLE) || (r_os_cnt == OS_LAST)) begin
            r_os_cnt <= '0;
        end else begin
            r_os_cnt <= r_os_cnt + OS_W'(1);
        end
    end

    // Frame state machine with registered strobes and data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (!enable) begin
                r_state    <= S_IDLE;
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_rxd_s) begin
                            r_state    <= S_START;
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                        end
                    end
                    S_START: begin
                        if (w_os_tick) begin
                            if (r_tick_cnt == TICK_MID) begin
                                // Mid start bit: a high line here was a glitch
                                r_tick_cnt <= '0;
                                r_state    <= w_rxd_s ? S_IDLE : S_DATA;
                            end else begin
                                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_os_tick) begin
                            if (r_tick_cnt == TICK_LAST) begin
                                r_tick_cnt <= '0;
                                r_shift    <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
                                if (r_bit_cnt == BIT_LAST) begin
                                    r_bit_cnt <= '0;
                                    r_state   <= S_STOP;
                                end else begin
                                    r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                                end
                            end else begin
                                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    S_STOP: begin
                        if (w_os_tick) begin
                            if (r_tick_cnt == TICK_LAST) begin
                                // Leaving at mid-stop lets a new start edge follow directly
                                r_tick_cnt <= '0;
                                if (w_rxd_s) begin
                                    rx_data  <= r_shift;
                                    rx_valid <= 1'b1;
                                    r_state  <= S_IDLE;
                                end else begin
                                    frame_err <= 1'b1;
                                    r_state   <= S_WAIT_IDLE;
                                end
                            end else begin
                                r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        // Line held low (break): wait for it to go idle again
                        if (w_rxd_s) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Scoreboard testbench for uart_rx at default parameters.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLK = 434;   // 50 MHz / 115200
    localparam int FAST    = 421;   // +3 % line rate
    localparam int SLOW    = 447;   // -3 % line rate

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       rx_busy;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good;
    int         checks;
    int         errors;
    time        t_edge;
    time        last_strobe_t;

    uart_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model: a frame with a high stop bit delivers its data, a low
    // stop bit yields a framing error and leaves the last good word visible.
    task automatic expect_frame(input logic [7:0] d, input bit stop_v);
        exp_t e;
        if (stop_v) begin
            e.is_err  = 1'b0;
            e.data    = d;
            last_good = d;
        end else begin
            e.is_err = 1'b1;
            e.data   = last_good;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v, input int per);
        rxd = v;
        repeat (per) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int per, input bit stop_v);
        t_edge = $time;
        send_bit(1'b0, per);
        for (int i = 0; i < 8; i++) send_bit(d[i], per);
        send_bit(stop_v, per);
    endtask

    // Monitor: every strobe must match the head of the expectation queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid && frame_err) begin
                check("strobe_overlap", 32'd1, 32'd0);
            end
            if (rx_valid || frame_err) begin
                last_strobe_t = $time;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {30'd0, frame_err, rx_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("strobe_kind", {31'd0, frame_err}, {31'd0, e.is_err});
                    check("strobe_data", {24'd0, rx_data}, {24'd0, e.data});
                end
            end
        end
    end

    // Watchdog against a hung run
    initial begin
        #950_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt;
        int lat;
        checks    = 0;
        errors    = 0;
        last_good = 8'h00;
        rst_n     = 1'b0;
        enable    = 1'b0;
        rxd       = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        idle(20);

        // Nominal frame and latency from start edge to strobe
        expect_frame(8'h55, 1'b1);
        send_frame(8'h55, BIT_CLK, 1'b1);
        idle(200);
        lat = int'((last_strobe_t - t_edge) / 10);
        check_range("latency_0x55", lat, 4105, 4109);

        // Short low glitch: START for half a bit, then back to IDLE
        busy_cnt = 0;
        rxd = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (i == 100) rxd = 1'b1;
            @(negedge clk);
            if (rx_busy) busy_cnt++;
        end
        check_range("glitch_busy_cycles", busy_cnt, 214, 218);

        // Low stop bit followed by a held-low line
        expect_frame(8'hA5, 1'b0);
        send_frame(8'hA5, BIT_CLK, 1'b0);
        rxd = 1'b0;
        repeat (2000) @(negedge clk);
        check("break_busy", {31'd0, rx_busy}, 32'd1);
        idle(10);
        check("break_released", {31'd0, rx_busy}, 32'd0);
        idle(190);
        expect_frame(8'h3C, 1'b1);
        send_frame(8'h3C, BIT_CLK, 1'b1);
        idle(200);

        // Back-to-back frames with no idle gap
        expect_frame(8'hA5, 1'b1);
        expect_frame(8'h3C, 1'b1);
        expect_frame(8'hFF, 1'b1);
        send_frame(8'hA5, BIT_CLK, 1'b1);
        send_frame(8'h3C, BIT_CLK, 1'b1);
        send_frame(8'hFF, BIT_CLK, 1'b1);
        idle(200);

        // Reset in the middle of data bit 2 of 0x12
        send_bit(1'b0, BIT_CLK);
        send_bit(1'b0, BIT_CLK);
        send_bit(1'b1, BIT_CLK);
        send_bit(1'b0, 200);
        rst_n = 1'b0;
        rxd   = 1'b1;
        last_good = 8'h00;
        repeat (10) @(negedge clk);
        check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
        check("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
        check("midreset_strobes", {30'd0, frame_err, rx_valid}, 32'd0);
        rst_n = 1'b1;
        idle(100);
        expect_frame(8'h34, 1'b1);
        send_frame(8'h34, BIT_CLK, 1'b1);
        idle(200);

        // Enable dropped mid-frame: frame discarded, data retained
        fork
            send_frame(8'h5A, BIT_CLK, 1'b1);
            begin
                repeat (2000) @(negedge clk);
                enable = 1'b0;
                @(negedge clk);
                check("disable_busy", {31'd0, rx_busy}, 32'd0);
            end
        join
        idle(500);
        check("disable_data_kept", {24'd0, rx_data}, {24'd0, last_good});
        enable = 1'b1;
        idle(20);
        expect_frame(8'h81, 1'b1);
        send_frame(8'h81, BIT_CLK, 1'b1);
        idle(200);

        // Line rate error of +/-3 %
        expect_frame(8'hC3, 1'b1);
        send_frame(8'hC3, FAST, 1'b1);
        idle(200);
        expect_frame(8'hC3, 1'b1);
        send_frame(8'hC3, SLOW, 1'b1);
        idle(200);

        // Randomised frames: data, rate within tolerance, occasional bad stop
        for (int n = 0; n < 4; n++) begin
            logic [7:0] d;
            int         per;
            bit         stop_v;
            d      = 8'($urandom_range(0, 255));
            per    = int'($urandom_range(FAST, SLOW));
            stop_v = ($urandom_range(0, 3) != 0);
            expect_frame(d, stop_v);
            send_frame(d, per, stop_v);
            if (!stop_v) begin
                rxd = 1'b0;
                repeat (50) @(negedge clk);
            end
            idle(int'($urandom_range(20, 300)));
        end

        idle(200);
        check("pending_expectations", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
